// File: rtl/gr8b0nd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gr8b0nd_pkg
// Description : Shared types and constants for the gr8b0nd sequential ALU.
//               Holds the 4-bit opcode enum, the execute FSM state enum,
//               the default datapath geometry and an opcode legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gr8b0nd_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_LANES = 2;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_MUL = 4'd1,
    OP_SH  = 4'd2,
    OP_SLT = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_NEG = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Codes above OP_NEG are reserved and flagged through err.
  function automatic logic op_is_legal(input logic [3:0] code);
    return (code <= 4'(OP_NEG));
  endfunction

endpackage : gr8b0nd_pkg
`default_nettype wire

// File: rtl/gr8b0nd_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : gr8b0nd_seq_mul
// Description : Iterative shift-add multiplier, one multiplier bit per cycle.
//               Produces the low WIDTH bits of b * a, either as one full word
//               or as LANES independent lanes (carry chain and operand shifts
//               are cut at lane boundaries in packed mode).
// Ports       : clk, reset (async, active-low)
//               start       - load operands and step count (WIDTH or LW)
//               packed_mode - 0 full word, 1 independent lanes
//               a           - multiplier, b - multiplicand
//               done        - high in the cycle whose edge performs the last step
//               product     - accumulator value written by the current step
// Revision    : 1.0 - initial release
// ============================================================================
module gr8b0nd_seq_mul
  import gr8b0nd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             packed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int LW = WIDTH / LANES;
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_count;
  logic             r_packed;

  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_mcand_next;
  logic [WIDTH-1:0] w_mplier_next;
  logic [LANES-1:0] w_cin;      // carry into each lane

  assign w_cin[0] = 1'b0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic          w_mbit;
    logic [LW-1:0] w_addend;
    logic          w_mc_in;
    logic          w_mp_in;

    // Packed lanes each consume their own multiplier LSB; full mode uses bit 0.
    assign w_mbit   = r_packed ? r_mplier[i*LW] : r_mplier[0];
    assign w_addend = w_mbit ? r_mcand[i*LW +: LW] : '0;

    if (i == 0) begin : g_first
      assign w_mc_in = 1'b0;
    end else begin : g_upper
      // Stop the multiplicand MSB of the lower lane leaking into this lane.
      assign w_mc_in = r_packed ? 1'b0 : r_mcand[i*LW-1];
    end

    if (i == LANES - 1) begin : g_last
      assign w_mp_in = 1'b0;
      // Carry out of the top lane is the discarded high half.
      assign w_acc_next[i*LW +: LW] = r_acc[i*LW +: LW] + w_addend + LW'(w_cin[i]);
    end else begin : g_inner
      logic [LW:0] w_lsum;
      assign w_mp_in = r_packed ? 1'b0 : r_mplier[(i+1)*LW];
      assign w_lsum  = {1'b0, r_acc[i*LW +: LW]} + {1'b0, w_addend} + {{LW{1'b0}}, w_cin[i]};
      assign w_cin[i+1] = r_packed ? 1'b0 : w_lsum[LW];
      assign w_acc_next[i*LW +: LW] = w_lsum[LW-1:0];
    end

    assign w_mcand_next[i*LW +: LW]  = {r_mcand[i*LW +: LW-1], w_mc_in};
    assign w_mplier_next[i*LW +: LW] = {w_mp_in, r_mplier[i*LW+1 +: LW-1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_packed <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= b;
      r_mplier <= a;
      r_packed <= packed_mode;
      r_count  <= packed_mode ? CW'(LW) : CW'(WIDTH);
    end else if (r_count != '0) begin
      r_acc    <= w_acc_next;
      r_mcand  <= w_mcand_next;
      r_mplier <= w_mplier_next;
      r_count  <= r_count - CW'(1);
    end
  end

  assign done    = (r_count == CW'(1));
  assign product = w_acc_next;

endmodule : gr8b0nd_seq_mul
`default_nettype wire

// File: rtl/gr8b0nd_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : gr8b0nd_seq_alu
// Description : Multicycle ALU with valid/ready handshakes. Single-cycle ops
//               are computed combinationally and registered on accept; MUL
//               runs on the iterative shift-add unit. Operates either on the
//               whole word or on LANES independent LW-bit lanes.
// Ports       : clk, reset (async, active-low)
//               in_valid / in_ready   - operation handshake (ready only in IDLE)
//               op, packed_mode, a, b - opcode, lane mode, source, destination
//               out_valid / out_ready - result handshake
//               result, carry, err    - registered result, per-lane ADD carry,
//                                       illegal-opcode flag
// Revision    : 1.0 - initial release
// ============================================================================
module gr8b0nd_seq_alu
  import gr8b0nd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             packed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [LANES-1:0] carry,
  output logic             err
);

  localparam int LW = WIDTH / LANES;

  state_e           r_state;
  logic [WIDTH-1:0] r_result;
  logic [LANES-1:0] r_carry;
  logic             r_err;

  // Index 0: full-word view, index 1: packed-lane view.
  logic [1:0][WIDTH-1:0] w_res_mode;
  logic [1:0][LANES-1:0] w_cy_mode;

  logic [WIDTH-1:0] w_res;
  logic [LANES-1:0] w_carry;
  logic             w_legal;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  // --------------------------------------------------------------------------
  // Single-cycle datapath, built once per unit size
  // --------------------------------------------------------------------------
  for (genvar m = 0; m < 2; m++) begin : g_mode
    localparam int UW = (m == 0) ? WIDTH : LW;
    localparam int NU = (m == 0) ? 1 : LANES;

    for (genvar u = 0; u < NU; u++) begin : g_unit
      localparam logic [UW:0] c_uw = (UW + 1)'(UW);

      logic [UW-1:0] w_ua;
      logic [UW-1:0] w_ub;
      logic [UW-1:0] w_mag;
      logic [UW:0]   w_sum;
      logic [UW-1:0] w_ures;
      logic          w_ucy;

      assign w_ua  = a[u*UW +: UW];
      assign w_ub  = b[u*UW +: UW];
      assign w_sum = {1'b0, w_ub} + {1'b0, w_ua};
      // Shift magnitude of the signed amount in a.
      assign w_mag = w_ua[UW-1] ? (-w_ua) : w_ua;

      always_comb begin
        w_ures = '0;
        w_ucy  = 1'b0;
        case (op)
          OP_ADD: begin
            w_ures = w_sum[UW-1:0];
            w_ucy  = w_sum[UW];
          end
          OP_SH: begin
            if ({1'b0, w_mag} >= c_uw) begin
              w_ures = '0;
            end else if (w_ua[UW-1]) begin
              w_ures = w_ub >> w_mag;
            end else begin
              w_ures = w_ub << w_mag;
            end
          end
          OP_SLT:  w_ures = UW'(w_ub < w_ua);
          OP_AND:  w_ures = w_ua & w_ub;
          OP_OR:   w_ures = w_ua | w_ub;
          OP_XOR:  w_ures = w_ua ^ w_ub;
          OP_NOT:  w_ures = ~w_ub;
          OP_NEG:  w_ures = -w_ub;
          default: w_ures = '0;   // MUL handled by the iterative unit; illegal ops give 0
        endcase
      end

      assign w_res_mode[m][u*UW +: UW] = w_ures;
      assign w_cy_mode[m][u]           = w_ucy;
    end

    if (NU < LANES) begin : g_cy_pad
      assign w_cy_mode[m][LANES-1:NU] = '0;
    end
  end

  assign w_res   = packed_mode ? w_res_mode[1] : w_res_mode[0];
  assign w_carry = packed_mode ? w_cy_mode[1]  : w_cy_mode[0];
  assign w_legal = op_is_legal(op);

  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_mul_start = w_accept && (op == OP_MUL);

  // --------------------------------------------------------------------------
  // Iterative multiplier
  // --------------------------------------------------------------------------
  gr8b0nd_seq_mul #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_mul (
    .clk         (clk),
    .reset       (reset),
    .start       (w_mul_start),
    .packed_mode (packed_mode),
    .a           (a),
    .b           (b),
    .done        (w_mul_done),
    .product     (w_mul_product)
  );

  // --------------------------------------------------------------------------
  // Execute FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_carry  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              r_state <= ST_MUL;
            end else begin
              r_state  <= ST_DONE;
              r_result <= w_res;
              r_carry  <= w_carry;
              r_err    <= !w_legal;
            end
          end
        end
        ST_MUL: begin
          // done marks the edge that writes the final partial product.
          if (w_mul_done) begin
            r_state  <= ST_DONE;
            r_result <= w_mul_product;
            r_carry  <= '0;
            r_err    <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign err       = r_err;

endmodule : gr8b0nd_seq_alu
`default_nettype wire

// File: tb/tb_gr8b0nd_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_gr8b0nd_seq_alu
// Description : Directed self-checking bench for gr8b0nd_seq_alu (16-bit,
//               2 lanes). Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gr8b0nd_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        packed_mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [1:0]  carry;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gr8b0nd_seq_alu #(
    .WIDTH (16),
    .LANES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .packed_mode (packed_mode),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .carry       (carry),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one op, let the next edge accept it, then count edges until
  // out_valid (accept edge counts as 1). Bounded at 64 edges.
  task automatic run_op(input logic [3:0] o, input logic pm, input logic [15:0] av,
                        input logic [15:0] bv, output int lat);
    op = o; packed_mode = pm; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  o;
    logic        pm;
    logic [15:0] av;
    logic [15:0] bv;
    logic [15:0] res;
    logic [1:0]  cy;
  } vec_t;

  vec_t tab [16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;

    tab = '{
      '{4'd0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 2'b01},  // ADD full wrap
      '{4'd0, 1'b1, 16'h80FF, 16'h8001, 16'h0000, 2'b11},  // ADD packed, both lanes carry
      '{4'd0, 1'b1, 16'h0001, 16'h00FF, 16'h0000, 2'b01},  // ADD packed, no inter-lane carry
      '{4'd0, 1'b0, 16'h1234, 16'h1111, 16'h2345, 2'b00},  // ADD full plain
      '{4'd2, 1'b0, 16'hFFFD, 16'h0080, 16'h0010, 2'b00},  // SH right by 3
      '{4'd2, 1'b0, 16'h0004, 16'h0001, 16'h0010, 2'b00},  // SH left by 4
      '{4'd2, 1'b0, 16'h0010, 16'hFFFF, 16'h0000, 2'b00},  // SH by width -> 0
      '{4'd2, 1'b1, 16'h02FE, 16'h0380, 16'h0C20, 2'b00},  // SH packed mixed
      '{4'd2, 1'b1, 16'h0808, 16'hFFFF, 16'h0000, 2'b00},  // SH packed by lane width
      '{4'd3, 1'b0, 16'h0005, 16'h0003, 16'h0001, 2'b00},  // SLT full
      '{4'd3, 1'b1, 16'h0105, 16'h0203, 16'h0001, 2'b00},  // SLT packed
      '{4'd4, 1'b0, 16'h0FF0, 16'h3C3C, 16'h0C30, 2'b00},  // AND
      '{4'd5, 1'b0, 16'h0FF0, 16'h3C3C, 16'h3FFC, 2'b00},  // OR
      '{4'd6, 1'b0, 16'h00FF, 16'h0F0F, 16'h0FF0, 2'b00},  // XOR
      '{4'd7, 1'b0, 16'h0000, 16'h00F0, 16'hFF0F, 2'b00},  // NOT
      '{4'd8, 1'b1, 16'h0000, 16'h0102, 16'hFFFE, 2'b00}   // NEG packed
    };

    reset = 1'b0; in_valid = 1'b0; op = '0; packed_mode = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result",    {16'd0, result},    32'd0);
    check("rst_carry",     {30'd0, carry},     32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops
    for (int i = 0; i < 16; i++) begin
      run_op(tab[i].o, tab[i].pm, tab[i].av, tab[i].bv, lat);
      check($sformatf("v%0d_result", i), {16'd0, result}, {16'd0, tab[i].res});
      check($sformatf("v%0d_carry", i),  {30'd0, carry},  {30'd0, tab[i].cy});
      check($sformatf("v%0d_err", i),    {31'd0, err},    32'd0);
      check($sformatf("v%0d_latency", i), lat, 32'd1);
      retire();
    end

    // MUL full: N = 16, previous carry nonzero must be cleared
    run_op(4'd0, 1'b1, 16'h80FF, 16'h8001, lat);
    retire();
    run_op(4'd1, 1'b0, 16'd300, 16'd200, lat);
    check("mul_full_result",  {16'd0, result}, 32'h0000EA60);
    check("mul_full_latency", lat, 32'd17);
    check("mul_full_carry",   {30'd0, carry}, 32'd0);
    retire();

    // MUL packed: N = 8, lanes isolated
    run_op(4'd1, 1'b1, 16'h0310, 16'h0204, lat);
    check("mul_pkd_result",  {16'd0, result}, 32'h00000640);
    check("mul_pkd_latency", lat, 32'd9);
    retire();

    // Illegal opcode
    run_op(4'hF, 1'b0, 16'h1234, 16'h5678, lat);
    check("illegal_result",  {16'd0, result}, 32'd0);
    check("illegal_err",     {31'd0, err},    32'd1);
    check("illegal_carry",   {30'd0, carry},  32'd0);
    check("illegal_latency", lat, 32'd1);
    retire();

    // Backpressure: result held, new op ignored until handshake
    run_op(4'd0, 1'b0, 16'd1, 16'd2, lat);
    check("bp_first_valid", {31'd0, out_valid}, 32'd1);
    op = 4'd0; packed_mode = 1'b0; a = 16'd5; b = 16'd5; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_result", k), {16'd0, result}, 32'd3);
      check($sformatf("bp_hold%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp_hold%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_in_ready",  {31'd0, in_ready},  32'd1);
    check("bp_hs_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_valid",  {31'd0, out_valid}, 32'd1);
    check("bp_new_result", {16'd0, result},    32'd10);
    retire();

    // Reset five edges into a full-width MUL
    op = 4'd1; packed_mode = 1'b0; a = 16'd300; b = 16'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_in_ready",  {31'd0, in_ready},  32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result",    {16'd0, result},    32'd0);
    check("abort_carry",     {30'd0, carry},     32'd0);
    check("abort_err",       {31'd0, err},       32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", seen, 32'd0);
    run_op(4'd0, 1'b0, 16'd2, 16'd3, lat);
    check("post_reset_add",     {16'd0, result}, 32'd5);
    check("post_reset_latency", lat, 32'd1);
    retire();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_gr8b0nd_seq_alu
`default_nettype wire

// File: doc/gr8b0nd_seq_alu.md
# gr8b0nd_seq_alu

Parametrised multicycle ALU for the gr8b0nd multicycle core. It executes one operation per handshake on `WIDTH`-bit operands, either as one full-width word or as `LANES` independent sub-words. Single-cycle ops complete in one cycle; multiply uses an iterative shift-add unit. Valid/ready handshakes on input and output let the processor FSM stall around a variable-latency execute stage.

## Interface
- `WIDTH`, 16: operand and result width; must be a multiple of `LANES`.
- `LANES`, 2: sub-word lane count in packed mode (1, 2 or 4); lane width `LW = WIDTH/LANES`.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `op`  in  4  0 ADD, 1 MUL, 2 SH, 3 SLT, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 NEG; 9–15 illegal.
- `packed`  in  1  0 = full-width word, 1 = `LANES` independent lanes.
- `a`  in  `WIDTH`  source operand.
- `b`  in  `WIDTH`  destination operand.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  `WIDTH`  registered result.
- `carry`  out  `LANES`  per-lane ADD carry-out; full mode uses bit 0 only, other bits 0.
- `err`  out  1  illegal opcode flag, valid with `out_valid`.

## Operation
- The block captures `op`, `packed`, `a` and `b` on the accept edge (`in_valid && in_ready`).
- The unit of operation is the whole word in full mode and each `LW`-bit lane in packed mode. There is no carry or borrow between lanes.
- ADD: `b + a` modulo the unit width. `carry` holds the carry-out of each unit.
- MUL: low half of `b * a` per unit, computed by iterative shift-add at one multiplier bit per cycle.
- SH: `a` is a signed shift amount.
  - If positive, the result is `b << a`.
  - If negative, the result is `b >> -a` (logical).
  - If zero, the result is `b`.
  - If the magnitude is at least the unit width, the result is 0.
- SLT: the unit result is 1 if `b < a` (unsigned), otherwise 0.
- AND, OR, XOR: bitwise `a` op `b`. NOT: `~b`. NEG: `-b` per unit.
- Illegal op: `result` = 0, `carry` = 0, `err` = 1. The operation completes with single-cycle latency.
- `carry` is 0 for every op other than ADD. `err` is 0 for every legal op.
- FSM:
  - IDLE: on accept, go to MUL if op = MUL, otherwise go to DONE.
  - MUL: count down `N` steps (`N = WIDTH` in full mode, `LW` in packed mode), then go to DONE.
  - DONE: hold `out_valid`. On `out_valid && out_ready`, go to IDLE.
- `in_ready` is 0 in MUL and DONE, so there is no overlap between operations. `in_valid` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, `in_ready` = 1, `out_valid` = 0, `result` = 0, `carry` = 0, `err` = 0, step counter 0.
- Single-cycle ops: `out_valid` rises on the edge after accept (latency 1).
- MUL: `out_valid` rises `N+1` edges after accept.
- `result`, `carry` and `err` are stable while `out_valid` is high, until the handshake completes.
- Output handshake: `in_ready` returns to 1 on the edge that completes `out_valid && out_ready`. The next accept is possible one cycle later, so peak throughput is one op every 2 cycles.
- `out_ready` high on the same cycle `out_valid` rises completes the handshake on that cycle.
- Reset asserted mid-operation (any state) aborts immediately:
  - outputs return to their reset values;
  - the partial product is discarded;
  - no `out_valid` pulse appears for the aborted op.

## Structure
- Package `gr8b0nd_pkg` holds:
  - the op enum (4-bit codes above);
  - the FSM state enum (IDLE, MUL, DONE);
  - default `WIDTH` and `LANES` constants.
- Sub-module `gr8b0nd_seq_mul`: `WIDTH`-bit iterative shift-add multiplier.
  - Takes a `packed` input that masks the partial-product carry chain at lane boundaries.
  - Uses `start`/`done` signalling with the step count selected by mode.
- The single-cycle datapath is combinational inside the top, with a registered output.

## Test plan
- ADD, full mode, `a`=0xFFFF, `b`=0x0001 -> `result`=0x0000, `carry`=2'b01, `out_valid` 1 cycle after accept.
- ADD, packed, `a`=0x80FF, `b`=0x8001 -> `result`=0x0000, `carry`=2'b11, no inter-lane carry.
- MUL timing and lane isolation:
  - full mode, `a`=300, `b`=200 -> `result`=0xEA60, `out_valid` exactly 17 edges after accept;
  - packed, `a`=0x0310, `b`=0x0204 -> `result`=0x0640, `out_valid` after 9 edges.
- SH: `a`=0xFFFD, `b`=0x0080 -> 0x0010; `a`=0x0004, `b`=0x0001 -> 0x0010; `a`=0x0010, `b`=0xFFFF -> 0x0000.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` and drive `in_valid`=1 with a new op -> `result` stable, `in_ready`=0, new op not accepted; accepted 1 cycle after the handshake.
- Reset and illegal op:
  - assert `reset` low 5 cycles into a full-mode MUL -> all outputs reach reset values, no `out_valid`; after release, ADD 2+3 returns 5;
  - op 0xF -> `result`=0, `err`=1.
